seq_detect_prog: RTL

- Runtime-programmable serial bit-pattern detector; parametrised successor of the fixed 4-bit sequence detector.
- Pattern and pattern length are loaded through a config port. Overlapping or non-overlapping detection is selectable. Input is qualified by a valid strobe.
- Keeps a saturating match counter.
- Sits on the serial test/stimulus datapath; reset defaults reproduce the legacy 1011 overlapping detector.

---
 rtl/seq_detect_pkg.sv | 19 +
 rtl/seq_detect_prog_if.sv | 29 ++
 rtl/seq_match_counter.sv | 28 ++
 rtl/seq_detect_prog.sv | 88 ++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
// Reset defaults reproduce the legacy fixed 1011 overlapping detector.
package seq_detect_pkg;

  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_LEN     = 4;
  localparam logic       DEF_OVERLAP = 1'b1;

  typedef enum logic {
    MODE_NON_OVERLAP = 1'b0,
    MODE_OVERLAP     = 1'b1
  } overlap_mode_e;

  // A pattern length is usable only if it is non-zero and fits the history register.
  function automatic logic len_legal(input int unsigned len_val, input int unsigned max_len);
    return (len_val != 0) && (len_val <= max_len);
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Config, serial-data and status signals of the sequence detector.
// The slave side is the detector; the master side is whoever drives the stimulus.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 6,
  parameter int CNT_W   = 8
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               in_valid;
  logic               inp_bit;
  logic               seq_seen;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;
  logic               cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr, in_valid, inp_bit,
    input  seq_seen, match_count, count_sat, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr, in_valid, inp_bit,
    output seq_seen, match_count, count_sat, cfg_err
  );
endinterface

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear and a sticky saturation flag.
// A hit arriving while the count is already all-ones is lost and raises sat.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  // Clear beats an increment on the same edge; the count holds at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        sat <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector.
// Newest bit enters hist[0]; only the low len bits of hist are compared to the
// pattern, and fill counts how many valid bits hist holds (capped at MAX_LEN).
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 6,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               reset,
  seq_detect_prog_if.slave  bus
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] pattern;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_n;
  overlap_mode_e      overlap;
  logic               err;
  logic               seen;
  logic               hit;
  logic               accept;

  assign accept = bus.in_valid && !bus.cfg_we;

  // Mask selecting the low len bits of the history for comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  // Next history, next fill level and the match decision for an accepted bit.
  always_comb begin
    hist_n = {hist[MAX_LEN-2:0], bus.inp_bit};
    fill_n = (fill >= LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    hit    = !err && (fill_n >= len) && (((hist_n ^ pattern) & mask) == '0);
  end

  // Config registers, shift history and match pulse; a config write drops the
  // concurrent data bit and restarts the history.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= MAX_LEN'(DEF_PATTERN);
      len     <= LEN_W'(DEF_LEN);
      overlap <= overlap_mode_e'(DEF_OVERLAP);
      err     <= 1'b0;
      seen    <= 1'b0;
    end else if (bus.cfg_we) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= bus.cfg_pattern;
      len     <= bus.cfg_len;
      overlap <= overlap_mode_e'(bus.cfg_overlap);
      err     <= !len_legal(32'(bus.cfg_len), MAX_LEN);
      seen    <= 1'b0;
    end else if (bus.in_valid) begin
      hist <= hist_n;
      fill <= (hit && overlap == MODE_NON_OVERLAP) ? '0 : fill_n;
      seen <= hit;
    end else begin
      seen <= 1'b0;
    end
  end

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.cnt_clr),
    .inc   (accept && hit),
    .count (bus.match_count),
    .sat   (bus.count_sat)
  );

  assign bus.seq_seen = seen;
  assign bus.cfg_err  = err;

endmodule
